led_ctrl: RTL
=============

LED_CTRL -- requirements
Module: led_ctrl

Interface
REQ-001 Parameter N_CH, default 3: number of LED channels, range 1..16.
REQ-002 Parameter PRESC_W, default 23: prescaler width; one tick every 2^PRESC_W clk cycles.
REQ-003 Parameter PWM_W, default 8: PWM counter and duty width.
REQ-004 Parameter LED_INV, default 0: 1 inverts every led output bit (active-low LEDs).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 cfg_we  input  1  config write strobe, one cycle per write.
REQ-008 cfg_ch  input  CH_W=max(1,clog2(N_CH))  target channel index.
REQ-009 cfg_mode  input  2  mode: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
REQ-010 cfg_div  input  2  blink rate select: toggle every 2^cfg_div ticks.
REQ-011 cfg_duty  input  PWM_W  PWM duty value.
REQ-012 led  output  N_CH  registered LED drive, bit i = channel i.
REQ-013 tick  output  1  one-cycle strobe on prescaler wrap.

Function
REQ-014 presc (PRESC_W bits) shall increment every clk, wrap from all-ones to 0.
REQ-015 tick shall be registered, high exactly the cycle after presc equals all-ones, else 0.
REQ-016 tcnt (4 bits) shall increment by 1 on each cycle tick is high, wrapping 15->0.
REQ-017 pwm_cnt (PWM_W bits) shall increment every clk, wrap to 0; shared by all channels.
REQ-018 Each channel shall hold mode, div, duty registers, written when cfg_we=1 and cfg_ch=i on the same edge.
REQ-019 cfg_we with cfg_ch >= N_CH shall be ignored; no channel changes.
REQ-020 Raw level: OFF->0; ON->1; BLINK->tcnt[div]; PWM->(pwm_cnt < duty), unsigned compare.
REQ-021 led[i] shall equal registered (raw level XOR LED_INV), one clk latency from counters/config.
REQ-022 Config written at edge k shall be reflected on led at edge k+1; counters never reset by writes (phase stays global).
REQ-023 PWM duty 0 shall give constant 0 raw; duty all-ones gives raw 1 for 2^PWM_W-1 of every 2^PWM_W cycles.
REQ-024 BLINK period shall be 2^(div+1) ticks, 50% duty; all BLINK channels with equal div in phase.
REQ-025 Simultaneous write and tick: counter advance and register write both take effect on that edge.

Reset
REQ-026 While rst=1: presc, tcnt, pwm_cnt = 0; all modes OFF, div 0, duty 0; tick = 0; led = {N_CH{LED_INV}}.
REQ-027 rst asserted mid-operation shall force reset values immediately, without waiting for clk.
REQ-028 First clk edge after rst deassertion shall start presc at 0->1; no spurious tick.

Structure
REQ-029 Package led_ctrl_pkg shall hold mode constants (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PWM) and CH_W function.
REQ-030 Sub-module led_ch (per-channel config registers + raw-level mux) shall be instantiated N_CH times by generate.
REQ-031 Shared counters shall live in led_ctrl top only; output register in top.
REQ-032 Target 120-400 lines RTL total.

Verification (PRESC_W=3, PWM_W=4, N_CH=3 unless noted)
REQ-033 Reset: rst=1 mid-run -> led=000, tick=0 asynchronously; release -> first tick 8 cycles later, then every 8.
REQ-034 Write ch1 ON at edge k -> led[1]=1 at edge k+1; ch0/ch2 unchanged; write cfg_ch=3 -> no change.
REQ-035 ch0 BLINK div=0 -> led[0] toggles every 8 clk; div=2 -> toggles every 32 clk, aligned to tcnt[2].
REQ-036 ch2 PWM duty=5 -> led[2] high 5 of each 16 clk; duty=0 -> always 0; duty=15 -> low 1 of 16.
REQ-037 LED_INV=1: after reset led=111; ON channel drives 0; PWM duty=5 gives low 5 of 16.
REQ-038 Write coinciding with tick cycle -> new mode at next edge and tcnt still increments once.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg -- shared definitions for the LED controller slice.
//   mode_e  : per-channel drive mode (OFF, ON, BLINK, PWM)
//   TCNT_W  : width of the tick counter that feeds BLINK
//   CH_W()  : channel-index width for a given channel count, never below 1
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  localparam int unsigned TCNT_W = 4;

  function automatic int unsigned CH_W(input int unsigned n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/led_ch.sv
// led_ch -- one LED channel: config registers plus raw-level select.
//   clk, rst   : clock, asynchronous active-high reset
//   i_we       : write enable, already decoded for this channel
//   i_mode     : mode to store (mode_e encoding)
//   i_div      : blink rate select, selects bit of i_tcnt
//   i_duty     : PWM duty to store
//   i_tcnt     : shared tick counter
//   i_pwm_cnt  : shared PWM counter
//   o_raw      : combinational raw level (before inversion/registering)
module led_ch
  import led_ctrl_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_mode,
  input  logic [1:0]        i_div,
  input  logic [PWM_W-1:0]  i_duty,
  input  logic [TCNT_W-1:0] i_tcnt,
  input  logic [PWM_W-1:0]  i_pwm_cnt,
  output logic              o_raw
);

  mode_e             r_mode;
  logic [1:0]        r_div;
  logic [PWM_W-1:0]  r_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_OFF;
      r_div  <= '0;
      r_duty <= '0;
    end else if (i_we) begin
      r_mode <= mode_e'(i_mode);
      r_div  <= i_div;
      r_duty <= i_duty;
    end
  end

  always_comb begin
    o_raw = 1'b0;
    case (r_mode)
      MODE_OFF:   o_raw = 1'b0;
      MODE_ON:    o_raw = 1'b1;
      // tcnt bit div toggles every 2^div ticks, so all channels with the
      // same div share phase through the global counter
      MODE_BLINK: o_raw = i_tcnt[r_div];
      MODE_PWM:   o_raw = (i_pwm_cnt < r_duty);
      default:    o_raw = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_ctrl.sv
// led_ctrl -- multi-channel LED controller with OFF/ON/BLINK/PWM modes.
//   clk, rst  : clock, asynchronous active-high reset
//   cfg_we    : config write strobe (one cycle per write)
//   cfg_ch    : target channel; indices >= N_CH are ignored
//   cfg_mode  : 0 OFF, 1 ON, 2 BLINK, 3 PWM
//   cfg_div   : blink toggles every 2^cfg_div ticks
//   cfg_duty  : PWM duty
//   led       : registered LED drive, bit i = channel i (inverted if LED_INV)
//   tick      : one-cycle strobe after the prescaler reaches all-ones
module led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int PRESC_W = 23,
  parameter int PWM_W   = 8,
  parameter int LED_INV = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_W(N_CH)-1:0]   cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [1:0]              cfg_div,
  input  logic [PWM_W-1:0]        cfg_duty,
  output logic [N_CH-1:0]         led,
  output logic                    tick
);

  localparam int unsigned  CFG_CH_W = CH_W(N_CH);
  localparam logic [N_CH-1:0] INV_MASK = (LED_INV != 0) ? '1 : '0;

  logic [PRESC_W-1:0] r_presc;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic               r_tick;
  logic [N_CH-1:0]    r_led;
  logic [N_CH-1:0]    w_we;
  logic [N_CH-1:0]    w_raw;

  // Shared counters: never touched by config writes, so phase is global.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc   <= '0;
      r_tick    <= 1'b0;
      r_tcnt    <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc   <= r_presc + PRESC_W'(1);
      r_tick    <= (r_presc == '1);
      if (r_tick)
        r_tcnt <= r_tcnt + TCNT_W'(1);
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    // out-of-range cfg_ch matches no channel, so such writes fall away
    assign w_we[gi] = cfg_we && (cfg_ch == CFG_CH_W'(gi));

    led_ch #(
      .PWM_W (PWM_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_we[gi]),
      .i_mode    (cfg_mode),
      .i_div     (cfg_div),
      .i_duty    (cfg_duty),
      .i_tcnt    (r_tcnt),
      .i_pwm_cnt (r_pwm_cnt),
      .o_raw     (w_raw[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_led <= INV_MASK;
    else
      r_led <= w_raw ^ INV_MASK;
  end

  assign led  = r_led;
  assign tick = r_tick;

endmodule
